// File: rtl/seq_detect_param.sv
// Parameterised serial pattern detector with Mealy match output and a registered copy.
// Define SEQ_DETECT_CNT_EN to add the saturating match_cnt output.
module seq_detect_param #(
    parameter int unsigned PATTERN_W = 8,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             in,
    input  logic                             in_vld,
    input  logic                             overlap,
    input  logic                             pat_load,
    input  logic [PATTERN_W-1:0]             pat_in,
    input  logic [$clog2(PATTERN_W+1)-1:0]   len_in,
    input  logic                             cnt_clr,
    output logic                             out,
    output logic                             sync_out
`ifdef SEQ_DETECT_CNT_EN
    ,
    output logic [CNT_W-1:0]                 match_cnt
`endif
);

    localparam int unsigned      LEN_W   = $clog2(PATTERN_W + 1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PATTERN_W);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    logic [PATTERN_W-1:0] pattern;
    logic [PATTERN_W-1:0] history;
    logic [PATTERN_W-1:0] cand;
    logic [PATTERN_W-1:0] mask;
    logic [LEN_W-1:0]     len;
    logic [LEN_W-1:0]     fill;
    logic [LEN_W-1:0]     len_clamped;
    logic                 consume;
    logic                 match;

    always_comb begin
        len_clamped = len_in;
        if (len_in == '0) begin
            len_clamped = LEN_ONE;
        end else if (len_in > LEN_MAX) begin
            len_clamped = LEN_MAX;
        end
    end

    // Only the low len bits of the candidate window take part in the compare.
    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < PATTERN_W; i++) begin
            if (i < 32'(len)) begin
                mask[i] = 1'b1;
            end
        end
    end

    assign cand    = {history[PATTERN_W-2:0], in};
    assign consume = in_vld & ~pat_load;
    assign match   = rstn & consume & (fill >= (len - LEN_ONE))
                   & (((cand ^ pattern) & mask) == '0);
    assign out     = match;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pattern  <= '0;
            len      <= LEN_MAX;
            history  <= '0;
            fill     <= '0;
            sync_out <= 1'b0;
        end else begin
            sync_out <= match;
            if (pat_load) begin
                pattern <= pat_in;
                len     <= len_clamped;
                history <= '0;
                fill    <= '0;
            end else if (in_vld) begin
                history <= cand;
                // Non-overlapping mode restarts the fill so matched bits are not reused.
                if (match && !overlap) begin
                    fill <= '0;
                end else if (fill != LEN_MAX) begin
                    fill <= fill + LEN_ONE;
                end
            end
        end
    end

`ifdef SEQ_DETECT_CNT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            match_cnt <= '0;
        end else if (cnt_clr) begin
            match_cnt <= '0;
        end else if (match && (match_cnt != '1)) begin
            match_cnt <= match_cnt + CNT_W'(1);
        end
    end
`else
    logic [CNT_W-1:0] unused_cnt_clr;
    assign unused_cnt_clr = {CNT_W{cnt_clr}};
`endif

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 SHALL have parameter PATTERN_W, default 8, maximum detectable pattern length in bits (range 2..32).
REQ-002 SHALL have parameter CNT_W, default 16, width of the match counter.
REQ-003 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in  input  1  serial data bit.
REQ-006 SHALL have port in_vld  input  1  qualifies in; the bit is consumed only when high.
REQ-007 SHALL have port overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-008 SHALL have port pat_load  input  1  load strobe for pattern and length.
REQ-009 SHALL have port pat_in  input  PATTERN_W  pattern; pat_in[len-1] is the first bit received, pat_in[0] is the last.
REQ-010 SHALL have port len_in  input  $clog2(PATTERN_W+1)  active pattern length.
REQ-011 SHALL have port cnt_clr  input  1  synchronous clear of match_cnt.
REQ-012 SHALL have port out  output  1  Mealy match, combinational from current bit and state.
REQ-013 SHALL have port sync_out  output  1  out registered by one clk.
REQ-014 SHALL have port match_cnt  output  CNT_W  saturating match count; present only per REQ-031.

Function
REQ-015 SHALL hold a pattern register, a length register, a PATTERN_W-bit history shift register (bit0 = newest) and a fill counter saturating at PATTERN_W.
REQ-016 On pat_load, SHALL capture pat_in, capture len_in clamped to the range 1..PATTERN_W (0 maps to 1, values above PATTERN_W map to PATTERN_W), and clear history and fill.
REQ-017 When pat_load and in_vld are both high, load SHALL win: the bit is discarded and out=0 that cycle.
REQ-018 When in_vld is high and pat_load is low, SHALL shift in into history bit0 and increment fill (saturating).
REQ-019 out SHALL be 1 iff in_vld=1, pat_load=0, fill >= len-1, and {history[len-2:0], in} equals pattern[len-1:0]; for len=1, the compare is in == pattern[0].
REQ-020 out SHALL be 0 whenever in_vld=0, with history and fill held.
REQ-021 When overlap=0 and out=1, fill SHALL be set to 0 at the clock edge instead of incremented, so that no bit takes part in two matches.
REQ-022 When overlap=1 and out=1, fill SHALL increment normally.
REQ-023 overlap SHALL be sampled per cycle, and a change SHALL take effect on the next consumed bit without clearing state.
REQ-024 sync_out SHALL equal out from the previous clock cycle; latency is exactly 1 cycle.
REQ-025 out SHALL have no timing path from pattern or length changes in the same cycle; newly loaded values apply from the next cycle.

Reset
REQ-026 While rstn=0, SHALL asynchronously set sync_out=0, history=0, fill=0, pattern=0 and length=PATTERN_W, and match_cnt=0 if present.
REQ-027 out SHALL be 0 during reset regardless of in.
REQ-028 Reset asserted mid-stream SHALL discard partial matches; detection after release requires a full len bits.
REQ-029 Reset release SHALL be synchronised by the integrator; the block itself requires no further sequencing.

Configuration
REQ-030 Macro SEQ_DETECT_CNT_EN SHALL control the match counter.
REQ-031 With SEQ_DETECT_CNT_EN defined, SHALL provide match_cnt, incremented by 1 on each cycle with out=1 and saturating at 2^CNT_W-1.
REQ-032 With SEQ_DETECT_CNT_EN defined, cnt_clr SHALL set match_cnt to 0 and SHALL win over a simultaneous match.
REQ-033 Without SEQ_DETECT_CNT_EN defined, match_cnt SHALL be absent from the port list, cnt_clr SHALL be ignored, and no counter logic SHALL be synthesised.

Verification
REQ-034 The bench SHALL load pat_in=0b101 with len_in=3, set overlap=1 and stream 1,0,1,0,1 -> out=1 on bits 3 and 5, and sync_out=1 one cycle after each.
REQ-035 The bench SHALL repeat REQ-034 with overlap=0 -> out=1 on bit 3 only.
REQ-036 The bench SHALL stream 1,0 then hold in_vld=0 for 5 cycles with in=1, then send 1 -> out=0 while in_vld=0, then out=1 on the final bit.
REQ-037 The bench SHALL assert pat_load together with in_vld=1 on a bit that would complete a match -> out=0, and history is cleared.
REQ-038 The bench SHALL load len_in=0 with pat_in[0]=1 -> every valid 1 gives out=1; then load len_in=PATTERN_W+3 -> behaves as length PATTERN_W.
REQ-039 With SEQ_DETECT_CNT_EN defined and CNT_W=2, the bench SHALL produce 5 matches -> match_cnt=3; then assert cnt_clr in the same cycle as a match -> match_cnt=0.
